mux_scan_ctl: RTL and testbench

Four-channel scan controller that sits directly upstream and downstream of a 4-to-1 inverting tristate multiplexer (sn74ls353 style). It drives the mux select lines and active-low output enable, waits a programmable settle time per channel, samples the mux's inverted output, and presents the re-inverted 4-bit word with a one-cycle ready strobe. It is a simulation model; sampling of undriven or unknown levels is reported, not resolved.

---
 rtl/mux_scan_ctl.sv | 124 ++++++++++++
 tb/tb_mux_scan_ctl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctl.sv
// Scan controller for a 4:1 inverting tristate mux: steps the selects,
// waits the settle time, samples q and publishes the re-inverted word.
module mux_scan_ctl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       q,
    output logic       a1,
    output logic       a0,
    output logic       oe,
    output logic [3:0] d,
    output logic       busy,
    output logic       rdy,
    output logic       err
);

    localparam logic [3:0] LOAD =
        (SETTLE < 1)  ? 4'd1  :
        (SETTLE > 15) ? 4'd15 : 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        SAMP,
        DONE
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [1:0] ch;
    logic [1:0] ch_n;
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    logic [3:0] shadow;
    logic [3:0] shadow_n;
    logic [3:0] d_n;
    logic       oe_n;
    logic       err_n;
    logic       qbad;
    logic       qbit;

    assign {a1, a0} = ch;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            ch     <= 2'd0;
            cnt    <= 4'd0;
            shadow <= 4'd0;
            d      <= 4'd0;
            oe     <= 1'b1;
            err    <= 1'b0;
            busy   <= 1'b0;
            rdy    <= 1'b0;
        end else begin
            state  <= state_n;
            ch     <= ch_n;
            cnt    <= cnt_n;
            shadow <= shadow_n;
            d      <= d_n;
            oe     <= oe_n;
            err    <= err_n;
            busy   <= (state_n == SEL) || (state_n == SAMP);
            rdy    <= (state_n == DONE);
        end
    end

    // An undriven or unknown mux output is flagged and stored as 0.
    always_comb begin
        qbad = $isunknown(q);
        qbit = qbad ? 1'b0 : ~q;
    end

    always_comb begin
        state_n  = state;
        ch_n     = ch;
        cnt_n    = cnt;
        shadow_n = shadow;
        d_n      = d;
        oe_n     = oe;
        err_n    = err;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SEL;
                    ch_n    = 2'd0;
                    cnt_n   = LOAD;
                    oe_n    = 1'b0;
                    err_n   = 1'b0;
                end
            end
            SEL: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = SAMP;
                end
            end
            SAMP: begin
                shadow_n[ch] = qbit;
                if (qbad) begin
                    err_n = 1'b1;
                end
                if (ch != 2'd3) begin
                    ch_n    = ch + 2'd1;
                    cnt_n   = LOAD;
                    state_n = SEL;
                end else begin
                    d_n     = shadow_n;
                    oe_n    = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_scan_ctl.sv
// Bench for mux_scan_ctl: two instances (SETTLE 1 and 3) behind a
// behavioural inverting mux, checked against a time-based scan model.
module tb_mux_scan_ctl;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [3:0] c;
    int         xch;

    logic       s1_q, s1_a1, s1_a0, s1_oe, s1_busy, s1_rdy, s1_err;
    logic [3:0] s1_d;
    logic       s3_q, s3_a1, s3_a0, s3_oe, s3_busy, s3_rdy, s3_err;
    logic [3:0] s3_d;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_scan_ctl #(.SETTLE(1)) u1 (
        .clk(clk), .clr(clr), .start(start), .q(s1_q),
        .a1(s1_a1), .a0(s1_a0), .oe(s1_oe), .d(s1_d),
        .busy(s1_busy), .rdy(s1_rdy), .err(s1_err)
    );

    mux_scan_ctl #(.SETTLE(3)) u3 (
        .clk(clk), .clr(clr), .start(start), .q(s3_q),
        .a1(s3_a1), .a0(s3_a0), .oe(s3_oe), .d(s3_d),
        .busy(s3_busy), .rdy(s3_rdy), .err(s3_err)
    );

    // Inverting mux; xch selects a channel that reads as unknown.
    always_comb begin
        s1_q = ~c[{s1_a1, s1_a0}];
        if (xch >= 0 && !s1_oe && int'({s1_a1, s1_a0}) == xch)
            s1_q = 1'bx;
    end

    always_comb begin
        s3_q = ~c[{s3_a1, s3_a0}];
        if (xch >= 0 && !s3_oe && int'({s3_a1, s3_a0}) == xch)
            s3_q = 1'bx;
    end

    // Model: t counts edges since the accepted start (0 = idle).
    int         sp[2];
    int         t[2];
    int         ms[2];
    logic [3:0] sh[2];
    logic [3:0] md[2];
    logic       me[2];

    logic       probe;
    logic       fourstate;

    typedef struct {
        logic [3:0] c;
        int         xc;
        logic [3:0] dexp;
        logic       eexp;
    } vec_t;

    vec_t       tbl[5];
    int         got[2];
    logic [3:0] dv[2];
    logic       ev[2];

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            t[k]  = 0;
            ms[k] = 0;
            sh[k] = 4'd0;
            md[k] = 4'd0;
            me[k] = 1'b0;
        end
    endtask

    task automatic step(input logic st, input logic [1:0] qs);
        for (int k = 0; k < 2; k++) begin
            int p;
            int n;
            p = sp[k] + 1;
            if (t[k] == 0) begin
                if (st) begin
                    t[k]  = 1;
                    ms[k] = 0;
                    me[k] = 1'b0;
                end
            end else if (t[k] <= 4 * p) begin
                if (t[k] % p == 0) begin
                    n = t[k] / p - 1;
                    if ($isunknown(qs[k])) begin
                        sh[k][n] = 1'b0;
                        me[k]    = 1'b1;
                    end else begin
                        sh[k][n] = ~qs[k];
                    end
                    if (n == 3) md[k] = sh[k];
                end
                t[k]++;
                if (t[k] <= 4 * p) ms[k] = (t[k] - 1) / p;
            end else begin
                t[k] = 0;
            end
        end
    endtask

    function automatic logic [9:0] act(input int k);
        if (k == 0)
            return {s1_busy, s1_rdy, s1_oe, s1_a1, s1_a0, s1_d, s1_err};
        return {s3_busy, s3_rdy, s3_oe, s3_a1, s3_a0, s3_d, s3_err};
    endfunction

    task automatic chk(input int k);
        logic [9:0] e;
        logic [9:0] a;
        logic       b;
        int         p;
        p = sp[k] + 1;
        b = (t[k] >= 1) && (t[k] <= 4 * p);
        e = {b, t[k] == 4 * p + 1, !b, 2'(ms[k]), md[k], me[k]};
        a = act(k);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL cyc_s%0d at %0t got=%b want=%b",
                     sp[k], $time, a, e);
        end
    endtask

    task automatic chk_all();
        chk(0);
        chk(1);
    endtask

    // Called at a negedge with inputs already driven.
    task automatic tick();
        logic       st;
        logic [1:0] qs;
        #4;
        st = start;
        qs = {s3_q, s1_q};
        @(posedge clk);
        if (clr) mreset();
        else step(st, qs);
        @(negedge clk);
        chk_all();
    endtask

    task automatic clr_pulse();
        start = 1'b0;
        clr   = 1'b1;
        #1;
        mreset();
        chk_all();
        #1;
        clr = 1'b0;
        @(negedge clk);
        chk_all();
    endtask

    task automatic scan();
        start = 1'b1;
        tick();
        start = 1'b0;
        got[0] = -1;
        got[1] = -1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (s1_rdy && got[0] < 0) begin
                got[0] = i; dv[0] = s1_d; ev[0] = s1_err;
            end
            if (s3_rdy && got[1] < 0) begin
                got[1] = i; dv[1] = s3_d; ev[1] = s3_err;
            end
        end
    endtask

    task automatic expect_eq(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errs++;
            $display("FAIL %s got=%0d want=%0d", nm, a, e);
        end
    endtask

    initial begin
        int         nr;
        int         re[2];
        logic [3:0] rd[2];
        logic       seen;

        sp[0] = 1;
        sp[1] = 3;
        probe = 1'bx;
        fourstate = $isunknown(probe);

        tbl[0] = '{4'b1010, -1, 4'b1010, 1'b0};
        tbl[1] = '{4'b0101, -1, 4'b0101, 1'b0};
        tbl[2] = '{4'b0110, -1, 4'b0110, 1'b0};
        tbl[3] = '{4'b1111,  2, 4'b1011, 1'b1};
        tbl[4] = '{4'b0000, -1, 4'b0000, 1'b0};

        clr   = 1'b1;
        start = 1'b0;
        c     = 4'd0;
        xch   = -1;
        mreset();
        #1;
        chk_all();
        @(negedge clk);
        chk_all();
        clr = 1'b0;

        // Abort mid-scan after a completed 1100 scan.
        c = 4'b1100;
        scan();
        expect_eq("pre_abort_d", int'(dv[0]), 12);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        clr_pulse();
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (s1_rdy || s3_rdy) seen = 1'b1;
        end
        expect_eq("abort_no_rdy", int'(seen), 0);

        foreach (tbl[i]) begin
            c   = tbl[i].c;
            xch = tbl[i].xc;
            scan();
            xch = -1;
            for (int k = 0; k < 2; k++) begin
                expect_eq($sformatf("lat_s%0d_v%0d", sp[k], i),
                          got[k], 4 * (sp[k] + 1));
                if (tbl[i].xc < 0 || fourstate) begin
                    expect_eq($sformatf("d_s%0d_v%0d", sp[k], i),
                              int'(dv[k]), int'(tbl[i].dexp));
                    expect_eq($sformatf("err_s%0d_v%0d", sp[k], i),
                              int'(ev[k]), int'(tbl[i].eexp));
                end
            end
        end

        // Back-to-back with start held high.
        c     = 4'b1010;
        start = 1'b1;
        nr    = 0;
        re[0] = 0; re[1] = 0;
        rd[0] = 4'd0; rd[1] = 4'd0;
        for (int i = 0; i < 40 && nr < 2; i++) begin
            tick();
            if (s1_rdy) begin
                re[nr] = i;
                rd[nr] = s1_d;
                nr++;
                c = 4'b0101;
            end
        end
        start = 1'b0;
        expect_eq("b2b_count", nr, 2);
        expect_eq("b2b_gap", re[1] - re[0], 10);
        expect_eq("b2b_first", re[0], 8);
        expect_eq("b2b_d0", int'(rd[0]), 10);
        expect_eq("b2b_d1", int'(rd[1]), 5);
        repeat (20) tick();

        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 3) == 0);
            c     = 4'($urandom);
            if ($urandom_range(0, 79) == 0) clr_pulse();
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
